// File: rtl/serial_to_parallel_packer_pkg.sv
// ============================================================================
// Module  : serial_packer_pkg
// Brief   : Shared types and widths for the serial-to-parallel packer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package serial_packer_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  localparam int c_width_default = 16;

  // Length counter must represent WIDTH itself, hence the extra bit.
  localparam int CNT_W = $clog2(c_width_default) + 1;

  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_to_parallel_packer_if.sv
// ============================================================================
// Module  : serial_to_parallel_packer_if
// Brief   : Serial input / parallel word output bundle of the packer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface serial_to_parallel_packer_if #(
  parameter int WIDTH = serial_packer_pkg::c_width_default
);

  logic                                            data_i;
  logic                                            data_val_i;
  logic                                            flush_i;
  logic [WIDTH-1:0]                                deser_data_o;
  logic                                            deser_data_val_o;
  logic [serial_packer_pkg::cnt_width(WIDTH)-1:0]  deser_len_o;
  logic                                            busy_o;

  modport master (
    output data_i, data_val_i, flush_i,
    input  deser_data_o, deser_data_val_o, deser_len_o, busy_o
  );

  modport slave (
    input  data_i, data_val_i, flush_i,
    output deser_data_o, deser_data_val_o, deser_len_o, busy_o
  );

endinterface

`default_nettype wire

// File: rtl/serial_to_parallel_packer_bit_counter.sv
// ============================================================================
// Module  : serial_bit_counter
// Brief   : Accepted-bit counter, wraps after WIDTH bits, cleared by flush.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_bit_counter
  import serial_packer_pkg::*;
#(
  parameter int WIDTH = c_width_default
) (
  input  logic                          clk_i,
  input  logic                          arst_n_i,
  input  logic                          accept_i,
  input  logic                          clear_i,
  output logic [cnt_width(WIDTH)-1:0]   count_o
);

  localparam int                 c_cnt_w = cnt_width(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_count <= '0;
    end else if (clear_i || (accept_i && (r_count == c_last))) begin
      r_count <= '0;
    end else if (accept_i) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count_o = r_count;

endmodule

`default_nettype wire

// File: rtl/serial_to_parallel_packer.sv
// ============================================================================
// Module  : serial_to_parallel_packer
// Brief   : Packs a valid-qualified serial bit stream into WIDTH-bit words,
//           with flush of zero-padded partial words.
//           Define SERIAL_LSB_FIRST_EN for LSB-first bit placement.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_to_parallel_packer
  import serial_packer_pkg::*;
#(
  parameter int WIDTH = c_width_default
) (
  input  logic                          clk_i,
  input  logic                          arst_n_i,
  serial_to_parallel_packer_if.slave    bus
);

  localparam int                 c_cnt_w = cnt_width(WIDTH);
  localparam int                 c_idx_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  state_e               r_state;
  logic [WIDTH-1:0]     r_shift;
  logic [WIDTH-1:0]     r_data;
  logic                 r_val;
  logic [c_cnt_w-1:0]   r_len;
  logic                 r_busy;

  logic [c_cnt_w-1:0]   w_count;
  logic [c_cnt_w-1:0]   w_count_inc;
  logic [c_idx_w-1:0]   w_idx;
  logic [WIDTH-1:0]     w_shift_ins;
  logic                 w_full;
  logic                 w_flush;
  logic                 w_emit;

  serial_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .accept_i (bus.data_val_i),
    .clear_i  (w_flush),
    .count_o  (w_count)
  );

  // Count including the bit offered this cycle doubles as the emitted length.
  assign w_count_inc = w_count + {{(c_cnt_w-1){1'b0}}, bus.data_val_i};

`ifdef SERIAL_LSB_FIRST_EN
  assign w_idx = c_idx_w'(w_count);
`else
  assign w_idx = c_idx_w'(c_last - w_count);
`endif

  always_comb begin
    w_shift_ins = r_shift;
    if (bus.data_val_i) begin
      w_shift_ins[w_idx] = bus.data_i;
    end
  end

  assign w_full  = bus.data_val_i && (w_count == c_last);
  assign w_flush = bus.flush_i && ((r_state == COLLECT) || bus.data_val_i);
  assign w_emit  = w_full || w_flush;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_data  <= '0;
      r_val   <= 1'b0;
      r_len   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_val <= w_emit;
      if (w_emit) begin
        r_data  <= w_shift_ins;
        r_len   <= w_count_inc;
        r_shift <= '0;
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else if (bus.data_val_i) begin
        r_shift <= w_shift_ins;
        r_state <= COLLECT;
        r_busy  <= (w_count_inc != '0);
      end
    end
  end

  assign bus.deser_data_o     = r_data;
  assign bus.deser_data_val_o = r_val;
  assign bus.deser_len_o      = r_len;
  assign bus.busy_o           = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_serial_to_parallel_packer.sv
// ============================================================================
// Module  : tb_serial_to_parallel_packer
// Brief   : Directed self-checking bench for serial_to_parallel_packer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_to_parallel_packer;
  import serial_packer_pkg::*;

  localparam int c_w = 16;

`ifdef SERIAL_LSB_FIRST_EN
  localparam logic [15:0] c_exp_e70f  = 16'hF0E7;
  localparam logic [15:0] c_exp_flush = 16'h001D;
  localparam logic [15:0] c_exp_one   = 16'h0001;
  localparam logic [15:0] c_exp_0001  = 16'h8000;
`else
  localparam logic [15:0] c_exp_e70f  = 16'hE70F;
  localparam logic [15:0] c_exp_flush = 16'hB800;
  localparam logic [15:0] c_exp_one   = 16'h8000;
  localparam logic [15:0] c_exp_0001  = 16'h0001;
`endif
  localparam logic [CNT_W-1:0] c_len_full = CNT_W'(16);
  localparam logic [CNT_W-1:0] c_len_5    = CNT_W'(5);
  localparam logic [CNT_W-1:0] c_len_1    = CNT_W'(1);

  logic clk;
  logic arst_n;
  int   checks;
  int   failures;

  serial_to_parallel_packer_if #(.WIDTH(c_w)) bus ();

  serial_to_parallel_packer #(.WIDTH(c_w)) dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic d, input logic v, input logic f);
    bus.data_i     = d;
    bus.data_val_i = v;
    bus.flush_i    = f;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    bus.data_i = 1'b0; bus.data_val_i = 1'b0; bus.flush_i = 1'b0;
    #12;
    checks++; if (bus.deser_data_o !== 16'h0) begin failures++; $display("FAIL reset_data got=%h exp=0000", bus.deser_data_o); end
    checks++; if (bus.deser_data_val_o !== 1'b0) begin failures++; $display("FAIL reset_val got=%b exp=0", bus.deser_data_val_o); end
    checks++; if (bus.deser_len_o !== '0) begin failures++; $display("FAIL reset_len got=%0d exp=0", bus.deser_len_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_word();
    logic [15:0] pat;
    int pulses;
    pat = 16'hE70F;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      step(pat[15-i], 1'b1, 1'b0);
      if (i == 0) begin
        checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL full_busy_first got=%b exp=1", bus.busy_o); end
      end
      if (bus.deser_data_val_o) pulses++;
    end
    checks++; if (bus.deser_data_val_o !== 1'b1) begin failures++; $display("FAIL full_val got=%b exp=1", bus.deser_data_val_o); end
    checks++; if (bus.deser_data_o !== c_exp_e70f) begin failures++; $display("FAIL full_data got=%h exp=%h", bus.deser_data_o, c_exp_e70f); end
    checks++; if (bus.deser_len_o !== c_len_full) begin failures++; $display("FAIL full_len got=%0d exp=16", bus.deser_len_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL full_busy_after got=%b exp=0", bus.busy_o); end
    step(1'b0, 1'b0, 1'b0);
    if (bus.deser_data_val_o) pulses++;
    checks++; if (pulses != 1) begin failures++; $display("FAIL full_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_gaps();
    logic [15:0] pat;
    int pulses;
    pat = 16'hE70F;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      step(pat[15-i], 1'b1, 1'b0);
      if (bus.deser_data_val_o) pulses++;
      if (i == 3 || i == 10) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b1, 1'b0, 1'b0);
          if (bus.deser_data_val_o) pulses++;
          checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL gap_busy bit=%0d gap=%0d got=%b exp=1", i, g, bus.busy_o); end
        end
      end
    end
    checks++; if (bus.deser_data_o !== c_exp_e70f) begin failures++; $display("FAIL gap_data got=%h exp=%h", bus.deser_data_o, c_exp_e70f); end
    checks++; if (bus.deser_len_o !== c_len_full) begin failures++; $display("FAIL gap_len got=%0d exp=16", bus.deser_len_o); end
    step(1'b0, 1'b0, 1'b0);
    if (bus.deser_data_val_o) pulses++;
    checks++; if (pulses != 1) begin failures++; $display("FAIL gap_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_flush();
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++; if (bus.deser_data_val_o !== 1'b0) begin failures++; $display("FAIL flush_early_val got=%b exp=0", bus.deser_data_val_o); end
    step(1'b1, 1'b1, 1'b1);
    checks++; if (bus.deser_data_val_o !== 1'b1) begin failures++; $display("FAIL flush_val got=%b exp=1", bus.deser_data_val_o); end
    checks++; if (bus.deser_data_o !== c_exp_flush) begin failures++; $display("FAIL flush_data got=%h exp=%h", bus.deser_data_o, c_exp_flush); end
    checks++; if (bus.deser_len_o !== c_len_5) begin failures++; $display("FAIL flush_len got=%0d exp=5", bus.deser_len_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_flush_idle();
    step(1'b1, 1'b0, 1'b1);
    checks++; if (bus.deser_data_val_o !== 1'b0) begin failures++; $display("FAIL idle_flush_val got=%b exp=0", bus.deser_data_val_o); end
    checks++; if (bus.deser_data_o !== c_exp_flush) begin failures++; $display("FAIL idle_flush_data got=%h exp=%h", bus.deser_data_o, c_exp_flush); end
    checks++; if (bus.deser_len_o !== c_len_5) begin failures++; $display("FAIL idle_flush_len got=%0d exp=5", bus.deser_len_o); end
  endtask

  task automatic test_one_bit_flushes();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1);
      checks++; if (bus.deser_data_val_o !== 1'b1) begin failures++; $display("FAIL onebit_val idx=%0d got=%b exp=1", i, bus.deser_data_val_o); end
      checks++; if (bus.deser_data_o !== c_exp_one) begin failures++; $display("FAIL onebit_data idx=%0d got=%h exp=%h", i, bus.deser_data_o, c_exp_one); end
      checks++; if (bus.deser_len_o !== c_len_1) begin failures++; $display("FAIL onebit_len idx=%0d got=%0d exp=1", i, bus.deser_len_o); end
    end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (bus.deser_data_val_o !== 1'b0) begin failures++; $display("FAIL onebit_after_val got=%b exp=0", bus.deser_data_val_o); end
  endtask

  task automatic test_flush_on_full();
    logic [15:0] pat;
    pat = 16'hE70F;
    for (int i = 0; i < 15; i++) step(pat[15-i], 1'b1, 1'b0);
    step(pat[0], 1'b1, 1'b1);
    checks++; if (bus.deser_data_val_o !== 1'b1) begin failures++; $display("FAIL fullflush_val got=%b exp=1", bus.deser_data_val_o); end
    checks++; if (bus.deser_data_o !== c_exp_e70f) begin failures++; $display("FAIL fullflush_data got=%h exp=%h", bus.deser_data_o, c_exp_e70f); end
    checks++; if (bus.deser_len_o !== c_len_full) begin failures++; $display("FAIL fullflush_len got=%0d exp=16", bus.deser_len_o); end
    step(1'b0, 1'b0, 1'b1);
    checks++; if (bus.deser_data_val_o !== 1'b0) begin failures++; $display("FAIL fullflush_absorbed got=%b exp=0", bus.deser_data_val_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL fullflush_busy got=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pat;
    int pulses;
    int first_idx;
    int second_idx;
    pat = {16'hFFFF, 16'h0001};
    pulses = 0;
    first_idx = -1;
    second_idx = -1;
    for (int i = 0; i < 32; i++) begin
      step(pat[31-i], 1'b1, 1'b0);
      if (bus.deser_data_val_o) begin
        pulses++;
        if (first_idx < 0) begin
          first_idx = i;
          checks++; if (bus.deser_data_o !== 16'hFFFF) begin failures++; $display("FAIL b2b_data0 got=%h exp=ffff", bus.deser_data_o); end
        end else begin
          second_idx = i;
          checks++; if (bus.deser_data_o !== c_exp_0001) begin failures++; $display("FAIL b2b_data1 got=%h exp=%h", bus.deser_data_o, c_exp_0001); end
          checks++; if (bus.deser_len_o !== c_len_full) begin failures++; $display("FAIL b2b_len1 got=%0d exp=16", bus.deser_len_o); end
        end
      end
    end
    checks++; if (pulses != 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
    checks++; if (first_idx != 15 || second_idx != 31) begin failures++; $display("FAIL b2b_timing got=%0d,%0d exp=15,31", first_idx, second_idx); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL b2b_busy got=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_async_reset();
    logic [15:0] pat;
    int pulses;
    pat = 16'hA5A5;
    pulses = 0;
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0);
    checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL arst_busy_before got=%b exp=1", bus.busy_o); end
    #3;
    arst_n = 1'b0;
    #1;
    checks++; if (bus.deser_data_o !== 16'h0) begin failures++; $display("FAIL arst_data got=%h exp=0000", bus.deser_data_o); end
    checks++; if (bus.deser_len_o !== '0) begin failures++; $display("FAIL arst_len got=%0d exp=0", bus.deser_len_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", bus.busy_o); end
    checks++; if (bus.deser_data_val_o !== 1'b0) begin failures++; $display("FAIL arst_val got=%b exp=0", bus.deser_data_val_o); end
    bus.data_val_i = 1'b0;
    @(posedge clk);
    #2;
    arst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(pat[15-i], 1'b1, 1'b0);
      if (bus.deser_data_val_o) pulses++;
    end
    checks++; if (bus.deser_data_o !== 16'hA5A5) begin failures++; $display("FAIL arst_new_data got=%h exp=a5a5", bus.deser_data_o); end
    checks++; if (bus.deser_len_o !== c_len_full) begin failures++; $display("FAIL arst_new_len got=%0d exp=16", bus.deser_len_o); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL arst_new_pulses got=%0d exp=1", pulses); end
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_full_word();
    test_gaps();
    test_flush();
    test_flush_idle();
    test_one_bit_flushes();
    test_flush_on_full();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
